// File: rtl/fifo_pipe_alu_if.sv
// Handshake bundle between a producer/consumer and the FIFO-fed arithmetic pipeline.
// The master side drives requests and data; the slave side (the FIFO) answers with status.
interface fifo_pipe_alu_if #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             pop;
    logic [1:0]       mode;
    logic             clr_err;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic             empty;
    logic             full;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, push_data, pop, mode, clr_err,
        input  pop_data, pop_valid, empty, full, level, overflow, underflow
    );

    modport slave (
        input  push, push_data, pop, mode, clr_err,
        output pop_data, pop_valid, empty, full, level, overflow, underflow
    );
endinterface

// File: rtl/fifo_pipe_alu.sv
// DEPTH-entry FIFO whose popped words run through NUM_STAGES registered add/sub/pass stages,
// each word carrying the op mode that was presented on its pop cycle.
module fifo_pipe_alu #(
    parameter int DEPTH      = 8,
    parameter int WIDTH      = 11,
    parameter int NUM_STAGES = 3,
    parameter int STEP       = 1,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_pipe_alu_if.slave        bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wPtr;
    logic [AW-1:0]    r_rPtr;
    logic [LW-1:0]    r_level;
    logic             r_overflow;
    logic             r_underflow;

    logic [WIDTH-1:0] r_stageData  [NUM_STAGES];
    logic [1:0]       r_stageMode  [NUM_STAGES];
    logic             r_stageValid [NUM_STAGES];

    logic w_empty;
    logic w_full;
    logic w_pushAcc;
    logic w_popAcc;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == LW'(DEPTH));
    assign w_pushAcc = bus.push & ~w_full;
    assign w_popAcc  = bus.pop & ~w_empty;

    // Carry/borrow come from the extra top bit; saturation clamps per stage.
    function automatic logic [WIDTH-1:0] applyOp(input logic [WIDTH-1:0] x, input logic [1:0] m);
        logic [WIDTH:0]   sum;
        logic [WIDTH:0]   diff;
        logic [WIDTH-1:0] res;
        sum  = {1'b0, x} + {1'b0, STEP_W};
        diff = {1'b0, x} - {1'b0, STEP_W};
        res  = x;
        case (m)
            2'b01:   res = (SATURATE != 0 && sum[WIDTH])  ? '1 : sum[WIDTH-1:0];
            2'b10:   res = (SATURATE != 0 && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
            default: res = x;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (w_pushAcc && !rst) begin
            r_mem[r_wPtr] <= bus.push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wPtr      <= '0;
            r_rPtr      <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_pushAcc) begin
                r_wPtr <= r_wPtr + AW'(1);
            end
            if (w_popAcc) begin
                r_rPtr <= r_rPtr + AW'(1);
            end
            if (w_pushAcc && !w_popAcc) begin
                r_level <= r_level + LW'(1);
            end else if (w_popAcc && !w_pushAcc) begin
                r_level <= r_level - LW'(1);
            end
            // A new error event beats a simultaneous clear.
            r_overflow  <= (r_overflow  & ~bus.clr_err) | (bus.push & w_full);
            r_underflow <= (r_underflow & ~bus.clr_err) | (bus.pop  & w_empty);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                r_stageData[i]  <= '0;
                r_stageMode[i]  <= 2'b00;
                r_stageValid[i] <= 1'b0;
            end
        end else begin
            if (w_popAcc) begin
                r_stageData[0]  <= applyOp(r_mem[r_rPtr], bus.mode);
                r_stageMode[0]  <= bus.mode;
                r_stageValid[0] <= 1'b1;
            end else begin
                r_stageData[0]  <= '0;
                r_stageMode[0]  <= 2'b00;
                r_stageValid[0] <= 1'b0;
            end
            for (int i = 1; i < NUM_STAGES; i++) begin
                if (r_stageValid[i-1]) begin
                    r_stageData[i]  <= applyOp(r_stageData[i-1], r_stageMode[i-1]);
                    r_stageMode[i]  <= r_stageMode[i-1];
                    r_stageValid[i] <= 1'b1;
                end else begin
                    r_stageData[i]  <= '0;
                    r_stageMode[i]  <= 2'b00;
                    r_stageValid[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.pop_data  = r_stageData[NUM_STAGES-1];
    assign bus.pop_valid = r_stageValid[NUM_STAGES-1];
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.level     = r_level;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_fifo_pipe_alu.sv
// Drives a wrapping and a saturating fifo_pipe_alu with identical stimulus and checks both
// against a queue-based model plus a hand-written table of fill/drain/error vectors.
module tb_fifo_pipe_alu;
    localparam int WIDTH = 11;
    localparam int DEPTH = 8;
    localparam int NS    = 3;
    localparam int STEP  = 1;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_pipe_alu_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ifA ();
    fifo_pipe_alu_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ifB ();

    fifo_pipe_alu #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_STAGES(NS), .STEP(STEP), .SATURATE(0))
        dutWrap (.clk(clk), .rst(rst), .bus(ifA.slave));
    fifo_pipe_alu #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_STAGES(NS), .STEP(STEP), .SATURATE(1))
        dutSat (.clk(clk), .rst(rst), .bus(ifB.slave));

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int vWrap;
        int vSat;
    } pend_t;

    typedef struct {
        logic       push;
        int         data;
        logic       pop;
        logic [1:0] mode;
        logic       clr;
        int         expLevel;
        logic       expFull;
        logic       expEmpty;
        logic       expOv;
        logic       expUn;
        logic       expValid;
        int         expData;
    } vec_t;

    int    nChecks = 0;
    int    nFail   = 0;
    int    cyc     = 0;
    int    mq[$];
    pend_t pend[$];
    logic  ovM = 1'b0;
    logic  unM = 1'b0;
    int    lastA = -1;
    int    lastB = -1;
    int    validSeen = 0;
    vec_t  vecs[24];

    // Whole-pipeline result: the op is applied NS times, clamping only matters at the ends.
    function automatic int refWrap(input int x, input logic [1:0] m);
        int t = NS * (STEP & MAXV);
        if (m == 2'b01) return (x + t) % (MAXV + 1);
        if (m == 2'b10) return (((x - t) % (MAXV + 1)) + (MAXV + 1)) % (MAXV + 1);
        return x;
    endfunction

    function automatic int refSat(input int x, input logic [1:0] m);
        int t = NS * (STEP & MAXV);
        if (m == 2'b01) return (x + t > MAXV) ? MAXV : x + t;
        if (m == 2'b10) return (x - t < 0) ? 0 : x - t;
        return x;
    endfunction

    function automatic void checkVal(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    task automatic applyStimulus(input logic p, input int d, input logic q,
                                 input logic [1:0] m, input logic c, input logic r);
        rst           = r;
        ifA.push      = p;  ifB.push      = p;
        ifA.push_data = WIDTH'(d); ifB.push_data = WIDTH'(d);
        ifA.pop       = q;  ifB.pop       = q;
        ifA.mode      = m;  ifB.mode      = m;
        ifA.clr_err   = c;  ifB.clr_err   = c;
    endtask

    // Compare both DUTs against the model's view after the edge just taken.
    task automatic checkOutput(input logic r, input logic p, input int d, input logic q,
                               input logic [1:0] m, input logic c);
        bit    expV = 1'b0;
        int    expA = 0;
        int    expB = 0;
        bit    fullPre;
        bit    emptyPre;
        pend_t e;
        cyc++;
        if (r) begin
            mq.delete();
            pend.delete();
            ovM = 1'b0;
            unM = 1'b0;
        end else begin
            fullPre  = (mq.size() == DEPTH);
            emptyPre = (mq.size() == 0);
            ovM = (ovM && !c) || (p && fullPre);
            unM = (unM && !c) || (q && emptyPre);
            if (q && !emptyPre) begin
                int x = mq.pop_front();
                e.due   = cyc + NS - 1;
                e.vWrap = refWrap(x, m);
                e.vSat  = refSat(x, m);
                pend.push_back(e);
            end
            if (p && !fullPre) mq.push_back(d & MAXV);
            if (pend.size() > 0 && pend[0].due == cyc) begin
                e = pend.pop_front();
                expV = 1'b1;
                expA = e.vWrap;
                expB = e.vSat;
            end
        end
        checkVal("validWrap", int'(ifA.pop_valid), int'(expV));
        checkVal("dataWrap",  int'(ifA.pop_data),  expA);
        checkVal("validSat",  int'(ifB.pop_valid), int'(expV));
        checkVal("dataSat",   int'(ifB.pop_data),  expB);
        checkVal("level",     int'(ifA.level),     mq.size());
        checkVal("levelSat",  int'(ifB.level),     mq.size());
        checkVal("empty",     int'(ifA.empty),     int'(mq.size() == 0));
        checkVal("full",      int'(ifA.full),      int'(mq.size() == DEPTH));
        checkVal("overflow",  int'(ifA.overflow),  int'(ovM));
        checkVal("underflow", int'(ifA.underflow), int'(unM));
        if (ifA.pop_valid) begin
            lastA = int'(ifA.pop_data);
            validSeen++;
        end
        if (ifB.pop_valid) lastB = int'(ifB.pop_data);
    endtask

    task automatic stepCycle(input logic p, input int d, input logic q,
                             input logic [1:0] m, input logic c, input logic r);
        applyStimulus(p, d, q, m, c, r);
        @(posedge clk);
        #1;
        checkOutput(r, p, d, q, m, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) stepCycle(1'b0, 0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        stepCycle(1'b0, 0, 1'b0, 2'b00, 1'b0, 1'b1);
    endtask

    initial begin
        applyStimulus(1'b0, 0, 1'b0, 2'b00, 1'b0, 1'b1);

        // Fill/drain/error table, expected values written out by hand.
        for (int r = 0; r < 24; r++) begin
            vecs[r] = '{push: 1'b0, data: 0, pop: 1'b0, mode: 2'b00, clr: 1'b0,
                        expLevel: 0, expFull: 1'b0, expEmpty: 1'b1, expOv: 1'b0,
                        expUn: 1'b0, expValid: 1'b0, expData: 0};
            if (r < 8) begin
                vecs[r].push = 1'b1; vecs[r].data = r;
                vecs[r].expLevel = r + 1; vecs[r].expFull = (r == 7); vecs[r].expEmpty = 1'b0;
            end else if (r == 8) begin
                vecs[r].push = 1'b1; vecs[r].data = 100;
                vecs[r].expLevel = 8; vecs[r].expFull = 1'b1; vecs[r].expEmpty = 1'b0;
                vecs[r].expOv = 1'b1;
            end else if (r == 9) begin
                vecs[r].clr = 1'b1;
                vecs[r].expLevel = 8; vecs[r].expFull = 1'b1; vecs[r].expEmpty = 1'b0;
            end else if (r < 18) begin
                vecs[r].pop = 1'b1; vecs[r].mode = 2'b01;
                vecs[r].expLevel = 17 - r; vecs[r].expEmpty = (r == 17);
            end else if (r == 21) begin
                vecs[r].pop = 1'b1; vecs[r].expUn = 1'b1;
            end else if (r == 22) begin
                vecs[r].pop = 1'b1; vecs[r].clr = 1'b1; vecs[r].expUn = 1'b1;
            end else if (r == 23) begin
                vecs[r].clr = 1'b1;
            end
            if (r >= 12 && r <= 19) begin
                vecs[r].expValid = 1'b1; vecs[r].expData = r - 9;
            end
        end

        doReset();
        checkVal("rstEmpty", int'(ifA.empty), 1);
        checkVal("rstFull", int'(ifA.full), 0);
        checkVal("rstValid", int'(ifA.pop_valid), 0);
        checkVal("rstData", int'(ifA.pop_data), 0);

        for (int r = 0; r < 24; r++) begin
            stepCycle(vecs[r].push, vecs[r].data, vecs[r].pop, vecs[r].mode, vecs[r].clr, 1'b0);
            checkVal($sformatf("tblLevel%0d", r), int'(ifA.level), vecs[r].expLevel);
            checkVal($sformatf("tblFull%0d", r), int'(ifA.full), int'(vecs[r].expFull));
            checkVal($sformatf("tblEmpty%0d", r), int'(ifA.empty), int'(vecs[r].expEmpty));
            checkVal($sformatf("tblOv%0d", r), int'(ifA.overflow), int'(vecs[r].expOv));
            checkVal($sformatf("tblUn%0d", r), int'(ifA.underflow), int'(vecs[r].expUn));
            checkVal($sformatf("tblValid%0d", r), int'(ifA.pop_valid), int'(vecs[r].expValid));
            checkVal($sformatf("tblData%0d", r), int'(ifA.pop_data), vecs[r].expData);
            checkVal($sformatf("tblDataSat%0d", r), int'(ifB.pop_data), vecs[r].expData);
        end

        // Push and pop together at full: the pop wins, the push is dropped and flagged.
        doReset();
        for (int i = 0; i < DEPTH; i++) stepCycle(1'b1, 50 + i, 1'b0, 2'b00, 1'b0, 1'b0);
        stepCycle(1'b1, 999, 1'b1, 2'b00, 1'b0, 1'b0);
        checkVal("pushPopFullLevel", int'(ifA.level), 7);
        checkVal("pushPopFullOv", int'(ifA.overflow), 1);
        stepCycle(1'b0, 0, 1'b0, 2'b00, 1'b1, 1'b0);
        checkVal("clrOv", int'(ifA.overflow), 0);
        for (int i = 0; i < 7; i++) stepCycle(1'b0, 0, 1'b1, 2'b00, 1'b0, 1'b0);
        idle(NS);

        // Arithmetic edges for both wrap and saturate builds.
        doReset();
        stepCycle(1'b1, 2046, 1'b0, 2'b00, 1'b0, 1'b0);
        stepCycle(1'b0, 0, 1'b1, 2'b01, 1'b0, 1'b0);
        idle(NS);
        checkVal("addWrapEdge", lastA, 1);
        checkVal("addSatEdge", lastB, 2047);
        stepCycle(1'b1, 1, 1'b0, 2'b00, 1'b0, 1'b0);
        stepCycle(1'b0, 0, 1'b1, 2'b10, 1'b0, 1'b0);
        idle(NS);
        checkVal("subWrapEdge", lastA, 2046);
        checkVal("subSatEdge", lastB, 0);

        // Pointer wrap with the mode cycling pass/add/sub under steady push+pop.
        doReset();
        for (int i = 0; i < 5; i++) stepCycle(1'b1, int'($urandom_range(0, MAXV)), 1'b0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            logic [1:0] m;
            m = 2'(i % 3);
            stepCycle(1'b1, int'($urandom_range(0, MAXV)), 1'b1, m, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) stepCycle(1'b0, 0, 1'b1, 2'b01, 1'b0, 1'b0);
        idle(NS);

        // Reset with two words still travelling down the pipeline.
        doReset();
        stepCycle(1'b1, 10, 1'b0, 2'b00, 1'b0, 1'b0);
        stepCycle(1'b1, 20, 1'b0, 2'b00, 1'b0, 1'b0);
        stepCycle(1'b0, 0, 1'b1, 2'b01, 1'b0, 1'b0);
        stepCycle(1'b0, 0, 1'b1, 2'b10, 1'b0, 1'b0);
        doReset();
        validSeen = 0;
        idle(6);
        checkVal("midRstNoLateWords", validSeen, 0);
        checkVal("midRstEmpty", int'(ifA.empty), 1);

        // Random traffic including occasional resets and error clears.
        for (int i = 0; i < 500; i++) begin
            logic p, q, c, r;
            logic [1:0] m;
            p = ($urandom_range(0, 99) < 55);
            q = ($urandom_range(0, 99) < 50);
            c = ($urandom_range(0, 99) < 10);
            r = ($urandom_range(0, 99) < 2);
            m = 2'($urandom_range(0, 3));
            stepCycle(p, int'($urandom_range(0, MAXV)), q, m, c, r);
        end
        idle(NS + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
